// File: rtl/bash_cmd_executor.sv
// bash_cmd_executor: shell endpoint of the bash line protocol (read a command line, decode it,
// stream one response line back, pulse solved, wait for ack). BASH_CALC_EN adds "add A B".
module bash_cmd_executor #(
   parameter int LINE_MAX = 32,
   parameter int RESP_MAX = 64
`ifdef BASH_CALC_EN
   ,
   parameter int ADD_DIGITS = 4
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       line_ready,
   input  logic [5:0] line_len,
   input  logic [7:0] line_char,
   output logic       line_next,
   output logic       resp_ready,
   output logic [7:0] resp_char,
   input  logic       resp_next,
   output logic       solved,
   input  logic       solved_ack,
   output logic       busy
);
   localparam int IW = $clog2(LINE_MAX);
   localparam logic [5:0] LMAX = 6'(LINE_MAX);
   localparam logic [6:0] RMAX = 7'(RESP_MAX);

   localparam int LEN_HELLO = 13;
   localparam logic [8*LEN_HELLO-1:0] STR_HELLO = "Hello, world!";
   localparam int LEN_UNK = 15;
   localparam logic [8*LEN_UNK-1:0] STR_UNK = "Unknown command";
`ifdef BASH_CALC_EN
   localparam int LEN_HELP = 19;
   localparam logic [8*LEN_HELP-1:0] STR_HELP = "hello echo help add";
   localparam int LEN_SYN = 12;
   localparam logic [8*LEN_SYN-1:0] STR_SYN = "Syntax error";
`else
   localparam int LEN_HELP = 15;
   localparam logic [8*LEN_HELP-1:0] STR_HELP = "hello echo help";
`endif

   typedef enum logic [2:0] {S_IDLE, S_RX, S_PARSE, S_TX, S_SOLVE, S_WAIT_ACK} state_t;
   typedef enum logic [2:0] {R_HELLO, R_ECHO, R_HELP, R_UNKNOWN, R_SUM, R_SYNTAX} resp_t;

   state_t      state_q, state_d;
   resp_t       sel_q, sel_d;
   logic [5:0]  len_q, len_d;
   logic [5:0]  rx_cnt_q, rx_cnt_d;
   logic        prev_take_q, prev_take_d;
   logic [6:0]  idx_q, idx_d;
   logic [7:0]  buf_q [LINE_MAX];

   logic [5:0]  n_len;
   logic [39:0] head5;
   logic        is_hello, is_echo, is_help;
   logic [6:0]  epos;
   logic [7:0]  ch;

`ifdef BASH_CALC_EN
   localparam int ACC_W = $clog2(10**ADD_DIGITS);
   localparam int SUM_W = ACC_W + 1;
   localparam int DIG_N = ADD_DIGITS + 1;
   localparam int DIW   = $clog2(DIG_N);
   localparam int DCW   = $clog2(DIG_N + 1);
   localparam int OCW   = $clog2(ADD_DIGITS + 1);
   localparam logic [OCW-1:0] DMAX = OCW'(ADD_DIGITS);

   typedef enum logic [1:0] {PH_A, PH_B, PH_CONV} phase_t;

   logic             calc_on_q, calc_on_d;
   phase_t           phase_q, phase_d;
   logic [5:0]       pos_q, pos_d;
   logic [OCW-1:0]   dcnt_q, dcnt_d;
   logic [ACC_W-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [DCW-1:0]   dig_n_q, dig_n_d;
   logic [3:0]       dig_q [DIG_N];
   logic             dig_push;
   logic             is_add, calc_isdig;
   logic [7:0]       calc_c;
   logic [3:0]       calc_d;

   assign is_add     = (n_len == 6'd3 && head5[39:16] == "add") ||
                       (n_len >= 6'd4 && head5[39:8] == "add ");
   assign calc_c     = buf_q[pos_q[IW-1:0]];
   assign calc_isdig = (calc_c >= "0") && (calc_c <= "9");
   assign calc_d     = 4'(calc_c - 8'h30);
`endif

   assign n_len    = (rx_cnt_q > LMAX) ? LMAX : rx_cnt_q;
   assign head5    = {buf_q[0], buf_q[1], buf_q[2], buf_q[3], buf_q[4]};
   assign is_hello = (n_len == 6'd5) && (head5 == "hello");
   assign is_echo  = ((n_len == 6'd4) && (head5[39:8] == "echo")) ||
                     ((n_len >= 6'd5) && (head5 == "echo "));
   assign is_help  = (n_len == 6'd4) && (head5[39:8] == "help");

   assign busy       = (state_q != S_IDLE);
   assign solved     = (state_q == S_SOLVE);
   assign resp_ready = (state_q == S_TX);
   assign resp_char  = ch;
   assign epos       = idx_q + 7'd5;

   // Response character is a pure function of (sel, idx), so it stays stable while stalled.
   always_comb begin
      ch = 8'h00;
      case (sel_q)
         R_HELLO:   if (idx_q < 7'(LEN_HELLO)) ch = STR_HELLO[8*(LEN_HELLO-1-int'(idx_q)) +: 8];
         R_HELP:    if (idx_q < 7'(LEN_HELP))  ch = STR_HELP[8*(LEN_HELP-1-int'(idx_q)) +: 8];
         R_UNKNOWN: if (idx_q < 7'(LEN_UNK))   ch = STR_UNK[8*(LEN_UNK-1-int'(idx_q)) +: 8];
         R_ECHO:    if (epos < {1'b0, n_len})  ch = buf_q[epos[IW-1:0]];
`ifdef BASH_CALC_EN
         R_SYNTAX:  if (idx_q < 7'(LEN_SYN))   ch = STR_SYN[8*(LEN_SYN-1-int'(idx_q)) +: 8];
         R_SUM:     if (idx_q < 7'(dig_n_q))
                       ch = {4'h3, dig_q[DIW'(dig_n_q - 1 - idx_q)]};
`endif
         default:   ch = 8'h00;
      endcase
      if (idx_q >= RMAX || state_q != S_TX) ch = 8'h00;
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      len_d       = len_q;
      rx_cnt_d    = rx_cnt_q;
      prev_take_d = 1'b0;
      idx_d       = idx_q;
      line_next   = 1'b0;
`ifdef BASH_CALC_EN
      calc_on_d = calc_on_q;
      phase_d   = phase_q;
      pos_d     = pos_q;
      dcnt_d    = dcnt_q;
      acc_a_d   = acc_a_q;
      acc_b_d   = acc_b_q;
      sum_d     = sum_q;
      dig_n_d   = dig_n_q;
      dig_push  = 1'b0;
`endif
      case (state_q)
         S_IDLE: if (line_ready) begin
            len_d    = line_len;
            rx_cnt_d = 6'd0;
            state_d  = (line_len == 6'd0) ? S_PARSE : S_RX;
         end
         S_RX: begin
            if (rx_cnt_q == len_q || !line_ready) begin
               state_d = S_PARSE;
            end else if (!prev_take_q) begin
               line_next   = 1'b1;
               prev_take_d = 1'b1;
               rx_cnt_d    = rx_cnt_q + 6'd1;
            end
         end
         S_PARSE: begin
            idx_d = 7'd0;
`ifdef BASH_CALC_EN
            if (calc_on_q) begin
               // Serial operand scan; any deviation from "add <digits> <digits>" aborts.
               state_d = S_TX;
               sel_d   = R_SYNTAX;
               calc_on_d = 1'b0;
               case (phase_q)
                  PH_A: if (pos_q < n_len && calc_isdig && dcnt_q != DMAX) begin
                     acc_a_d = ACC_W'(acc_a_q * 10 + calc_d);
                     dcnt_d  = dcnt_q + 1'b1;
                     pos_d   = pos_q + 6'd1;
                     state_d = S_PARSE;
                     calc_on_d = 1'b1;
                  end else if (pos_q < n_len && calc_c == " " && dcnt_q != '0) begin
                     phase_d = PH_B;
                     dcnt_d  = '0;
                     pos_d   = pos_q + 6'd1;
                     state_d = S_PARSE;
                     calc_on_d = 1'b1;
                  end
                  PH_B: if (pos_q >= n_len && dcnt_q != '0) begin
                     sum_d   = SUM_W'(acc_a_q) + SUM_W'(acc_b_q);
                     phase_d = PH_CONV;
                     state_d = S_PARSE;
                     calc_on_d = 1'b1;
                  end else if (pos_q < n_len && calc_isdig && dcnt_q != DMAX) begin
                     acc_b_d = ACC_W'(acc_b_q * 10 + calc_d);
                     dcnt_d  = dcnt_q + 1'b1;
                     pos_d   = pos_q + 6'd1;
                     state_d = S_PARSE;
                     calc_on_d = 1'b1;
                  end
                  default: begin
                     dig_push = 1'b1;
                     dig_n_d  = dig_n_q + 1'b1;
                     sum_d    = SUM_W'(sum_q / 10);
                     if (sum_q < SUM_W'(10)) begin
                        sel_d = R_SUM;
                     end else begin
                        state_d   = S_PARSE;
                        calc_on_d = 1'b1;
                     end
                  end
               endcase
            end else if (is_add) begin
               calc_on_d = 1'b1;
               phase_d   = PH_A;
               pos_d     = 6'd4;
               dcnt_d    = '0;
               acc_a_d   = '0;
               acc_b_d   = '0;
               dig_n_d   = '0;
            end else
`endif
            if (n_len == 6'd0) begin
               state_d = S_SOLVE;
            end else begin
               state_d = S_TX;
               if (is_hello)     sel_d = R_HELLO;
               else if (is_echo) sel_d = R_ECHO;
               else if (is_help) sel_d = R_HELP;
               else              sel_d = R_UNKNOWN;
            end
         end
         S_TX: if (resp_next) begin
            if (ch == 8'h00) state_d = S_SOLVE;
            else             idx_d   = idx_q + 7'd1;
         end
         S_SOLVE:    state_d = S_WAIT_ACK;
         S_WAIT_ACK: if (solved_ack) state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sel_q       <= R_UNKNOWN;
         len_q       <= 6'd0;
         rx_cnt_q    <= 6'd0;
         prev_take_q <= 1'b0;
         idx_q       <= 7'd0;
         for (int i = 0; i < LINE_MAX; i++) buf_q[i] <= 8'h00;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         len_q       <= len_d;
         rx_cnt_q    <= rx_cnt_d;
         prev_take_q <= prev_take_d;
         idx_q       <= idx_d;
         // Characters past LINE_MAX are still acknowledged but never stored.
         if (line_next && rx_cnt_q < LMAX) buf_q[rx_cnt_q[IW-1:0]] <= line_char;
      end
   end

`ifdef BASH_CALC_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         calc_on_q <= 1'b0;
         phase_q   <= PH_A;
         pos_q     <= 6'd0;
         dcnt_q    <= '0;
         acc_a_q   <= '0;
         acc_b_q   <= '0;
         sum_q     <= '0;
         dig_n_q   <= '0;
         for (int i = 0; i < DIG_N; i++) dig_q[i] <= 4'd0;
      end else begin
         calc_on_q <= calc_on_d;
         phase_q   <= phase_d;
         pos_q     <= pos_d;
         dcnt_q    <= dcnt_d;
         acc_a_q   <= acc_a_d;
         acc_b_q   <= acc_b_d;
         sum_q     <= sum_d;
         dig_n_q   <= dig_n_d;
         if (dig_push) dig_q[dig_n_q[DIW-1:0]] <= 4'(sum_q % 10);
      end
   end
`endif
endmodule

// File: tb/tb_bash_cmd_executor.sv
// Scoreboard bench for bash_cmd_executor: tasks queue expected response chars, a negedge
// monitor pops and compares whenever the DUT presents resp_ready.
module tb_bash_cmd_executor;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       line_ready = 1'b0;
   logic [5:0] line_len = 6'd0;
   logic [7:0] line_char;
   logic       line_next;
   logic       resp_ready;
   logic [7:0] resp_char;
   logic       resp_next = 1'b0;
   logic       solved;
   logic       solved_ack = 1'b0;
   logic       busy;

   always #5 clk = ~clk;

   bash_cmd_executor dut (
      .clk(clk), .rst(rst), .line_ready(line_ready), .line_len(line_len),
      .line_char(line_char), .line_next(line_next), .resp_ready(resp_ready),
      .resp_char(resp_char), .resp_next(resp_next), .solved(solved),
      .solved_ack(solved_ack), .busy(busy)
   );

   // console side: presents line_mem[cidx], advances on every line_next
   logic [7:0] line_mem [64];
   int cur_len = 0;
   int cidx = 0;
   assign line_char = (cidx < cur_len) ? line_mem[cidx] : 8'h00;
   always @(posedge clk) begin
      if (!line_ready) cidx <= 0;
      else if (line_next) cidx <= cidx + 1;
   end

   int checks = 0;
   int failures = 0;
   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   logic [7:0] exp_q [$];
   int  nxt_cnt = 0;
   int  solved_cnt = 0;
   int  stall_n = 0;
   int  stall_used = 0;
   bit  hold_resp = 1'b0;

   always @(negedge clk) begin
      if (line_next) nxt_cnt <= nxt_cnt + 1;
      if (solved) solved_cnt <= solved_cnt + 1;
      if (line_next && solved) check("line_next_with_solved", 1, 0);
      if (rst || resp_next) begin
         resp_next <= 1'b0;
      end else if (resp_ready && !hold_resp) begin
         if (exp_q.size() == 0) begin
            check("resp_unexpected", int'(resp_char), -1);
         end else if (stall_used < stall_n) begin
            check("resp_stall_hold", int'(resp_char), int'(exp_q[0]));
            stall_used <= stall_used + 1;
         end else begin
            check("resp_char", int'(resp_char), int'(exp_q.pop_front()));
            resp_next <= 1'b1;
         end
      end
   end

   task automatic load_line(input string cmd, input int len);
      for (int i = 0; i < 64; i++) line_mem[i] = (i < cmd.len()) ? cmd[i] : 8'h00;
      cur_len  = len;
      line_len = 6'(len);
   endtask

   task automatic run_cmd(input string name, input string cmd, input int len,
                          input string resp, input bit has_resp);
      int base_n;
      int base_s;
      int c;
      if (has_resp) begin
         for (int i = 0; i < resp.len(); i++) exp_q.push_back(resp[i]);
         exp_q.push_back(8'h00);
      end
      @(posedge clk); #1;
      base_n = nxt_cnt;
      base_s = solved_cnt;
      load_line(cmd, len);
      line_ready = 1'b1;
      c = 0;
      while (solved_cnt == base_s && c < 3000) begin
         @(posedge clk); #1;
         c++;
      end
      check({name, "_solved_seen"}, int'(c < 3000), 1);
      check({name, "_busy_wait_ack"}, int'(busy), 1);
      line_ready = 1'b0;
      solved_ack = 1'b1;
      @(posedge clk); #1;
      solved_ack = 1'b0;
      check({name, "_idle_after_ack"}, int'(busy), 0);
      check({name, "_line_next_count"}, nxt_cnt - base_n, len);
      check({name, "_solved_pulses"}, solved_cnt - base_s, 1);
      check({name, "_resp_left"}, exp_q.size(), 0);
      exp_q.delete();
      $display("cmd %s: len=%0d done", name, len);
   endtask

   initial begin
      string xs;
      int c;
      #12;
      check("rst_resp_ready", int'(resp_ready), 0);
      check("rst_solved", int'(solved), 0);
      check("rst_line_next", int'(line_next), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_resp_char", int'(resp_char), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_cmd("hello", "hello", 5, "Hello, world!", 1'b1);
      run_cmd("empty", "", 0, "", 1'b0);
      stall_n = stall_used + 10;
      run_cmd("echo_abc", "echo abc", 8, "abc", 1'b1);
      run_cmd("echo_bare", "echo", 4, "", 1'b1);
`ifdef BASH_CALC_EN
      run_cmd("help", "help", 4, "hello echo help add", 1'b1);
`else
      run_cmd("help", "help", 4, "hello echo help", 1'b1);
`endif
      run_cmd("foo", "foo", 3, "Unknown command", 1'b1);
      run_cmd("hello_upper", "Hello", 5, "Unknown command", 1'b1);
      xs = "";
      for (int i = 0; i < 40; i++) xs = {xs, "x"};
      run_cmd("long_x40", xs, 40, "Unknown command", 1'b1);
`ifdef BASH_CALC_EN
      run_cmd("add_12_9999", "add 12 9999", 11, "10011", 1'b1);
      run_cmd("add_0_0", "add 0 0", 7, "0", 1'b1);
      run_cmd("add_bad", "add 1x 2", 8, "Syntax error", 1'b1);
      run_cmd("add_5dig", "add 12345 1", 11, "Syntax error", 1'b1);
`else
      run_cmd("add_nocalc", "add 1 2", 7, "Unknown command", 1'b1);
`endif

      // reset in the middle of a response
      hold_resp = 1'b1;
      @(posedge clk); #1;
      load_line("hello", 5);
      line_ready = 1'b1;
      c = 0;
      while (!resp_ready && c < 500) begin
         @(posedge clk); #1;
         c++;
      end
      check("midtx_reached", int'(resp_ready), 1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("midtx_rst_resp_ready", int'(resp_ready), 0);
      check("midtx_rst_solved", int'(solved), 0);
      check("midtx_rst_line_next", int'(line_next), 0);
      check("midtx_rst_busy", int'(busy), 0);
      line_ready = 1'b0;
      hold_resp = 1'b0;
      exp_q.delete();
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      run_cmd("hello_after_rst", "hello", 5, "Hello, world!", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
